ysyx_22041071_ex: RTL and testbench

- Execute stage of the 5-stage RV64 pipeline, directly downstream of the decode/operand stage.
- Consumes the registered operands and controls that the decode stage produces, and computes the ALU result and branch decision.
- Runs a multi-cycle divider with an FSM, then registers results into the EX/MEM pipeline register.
- Drives the same-cycle forwarding signals (result, rdest1_, reg_w_en3_) back to decode.

---
 rtl/ysyx_22041071_ex.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_ysyx_22041071_ex.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041071_ex.sv
// ysyx_22041071_ex: execute stage of the 5-stage RV64 pipeline.
// Computes the ALU result and branch decision for the instruction held by
// decode, forwards the result combinationally, and registers it into EX/MEM.
// Optional feature macro: YSYX_22041071_MULDIV_EN enables MUL/MULW and a
// multi-cycle radix-2 restoring divider for the DIV/REM family.
module ysyx_22041071_ex #(
    parameter int XLEN    = 64,
    parameter int DIV_CYC = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid4,
    input  logic            ready5,
    output logic            ready4,
    input  logic [XLEN-1:0] PC4,
    input  logic [31:0]     Ins3,
    input  logic            Brch2,
    input  logic            MEM_W_en2,
    input  logic            WB_sel2,
    input  logic [4:0]      ALU_ctrl2,
    input  logic            reg_w_en2,
    input  logic [XLEN-1:0] rt_data1,
    input  logic [4:0]      rdest1,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [11:0]     BImm2,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rdest1_,
    output logic            reg_w_en3_,
    output logic            Brch_taken,
    output logic [XLEN-1:0] BPC,
    output logic            valid5,
    output logic [XLEN-1:0] PC5,
    output logic [31:0]     Ins4,
    output logic            MEM_W_en3,
    output logic            WB_sel3,
    output logic            reg_w_en4,
    output logic [4:0]      rdest2,
    output logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] st_data
);

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,  OP_SUB   = 5'd1,  OP_SLL   = 5'd2,  OP_SLT   = 5'd3,
        OP_SLTU  = 5'd4,  OP_XOR   = 5'd5,  OP_SRL   = 5'd6,  OP_SRA   = 5'd7,
        OP_OR    = 5'd8,  OP_AND   = 5'd9,  OP_ADDW  = 5'd10, OP_SUBW  = 5'd11,
        OP_SLLW  = 5'd12, OP_SRLW  = 5'd13, OP_SRAW  = 5'd14, OP_BEQ   = 5'd15,
        OP_BNE   = 5'd16, OP_BLT   = 5'd17, OP_BGE   = 5'd18, OP_BLTU  = 5'd19,
        OP_BGEU  = 5'd20, OP_MUL   = 5'd21, OP_MULW  = 5'd22, OP_DIV   = 5'd23,
        OP_DIVU  = 5'd24, OP_REM   = 5'd25, OP_REMU  = 5'd26, OP_DIVW  = 5'd27,
        OP_DIVUW = 5'd28, OP_REMW  = 5'd29, OP_REMUW = 5'd30, OP_NONE  = 5'd31
    } alu_op_e;

    localparam int HALF = XLEN / 2;

    function automatic logic [XLEN-1:0] sext_w(input logic [HALF-1:0] v);
        return {{HALF{v[HALF-1]}}, v};
    endfunction

    alu_op_e         op;
    logic            fire;
    logic            alu_done;
    logic            cond;
    logic [XLEN-1:0] alu_res;
    logic [HALF-1:0] w_res;
    logic [5:0]      shamt;
    logic [4:0]      shamt_w;

    assign op         = alu_op_e'(ALU_ctrl2);
    assign shamt      = src_b[5:0];
    assign shamt_w    = src_b[4:0];
    assign fire       = valid4 & ready4;
    assign ready4     = ready5 & alu_done;
    assign rdest1_    = rdest1;
    assign reg_w_en3_ = reg_w_en2 & valid4;
    assign Brch_taken = Brch2 & cond & fire;
    assign BPC        = PC4 + {{(XLEN-13){BImm2[11]}}, BImm2, 1'b0};

    // Single-cycle ALU and branch condition evaluation.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        alu_res = '0;
        w_res   = '0;
        cond    = 1'b0;
        unique case (op)
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_SLL:  alu_res = src_a << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SRL:  alu_res = src_a >> shamt;
            OP_SRA:  alu_res = $signed(src_a) >>> shamt;
            OP_OR:   alu_res = src_a | src_b;
            OP_AND:  alu_res = src_a & src_b;
            OP_ADDW: begin
                w_res   = src_a[HALF-1:0] + src_b[HALF-1:0];
                alu_res = sext_w(w_res);
            end
            OP_SUBW: begin
                w_res   = src_a[HALF-1:0] - src_b[HALF-1:0];
                alu_res = sext_w(w_res);
            end
            OP_SLLW: begin
                w_res   = src_a[HALF-1:0] << shamt_w;
                alu_res = sext_w(w_res);
            end
            OP_SRLW: begin
                w_res   = src_a[HALF-1:0] >> shamt_w;
                alu_res = sext_w(w_res);
            end
            OP_SRAW: begin
                w_res   = $signed(src_a[HALF-1:0]) >>> shamt_w;
                alu_res = sext_w(w_res);
            end
            OP_BEQ:  cond = (src_a == src_b);
            OP_BNE:  cond = (src_a != src_b);
            OP_BLT:  cond = ($signed(src_a) <  $signed(src_b));
            OP_BGE:  cond = ($signed(src_a) >= $signed(src_b));
            OP_BLTU: cond = (src_a <  src_b);
            OP_BGEU: cond = (src_a >= src_b);
`ifdef YSYX_22041071_MULDIV_EN
            OP_MUL:  alu_res = src_a * src_b;
            OP_MULW: begin
                w_res   = src_a[HALF-1:0] * src_b[HALF-1:0];
                alu_res = sext_w(w_res);
            end
`endif
            default: alu_res = '0;
        endcase
    end

`ifdef YSYX_22041071_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_e;

    localparam int CNT_W = $clog2(DIV_CYC + 1);

    div_state_e      state;
    div_state_e      state_next;
    logic            is_div;
    logic            is_w;
    logic            is_signed;
    logic            is_rem;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] div_q;
    logic [XLEN-1:0] div_r;
    logic [XLEN-1:0] div_d;
    logic [CNT_W-1:0] div_cnt;
    logic            neg_q;
    logic            neg_r;
    logic            div_zero;
    logic [XLEN:0]   shifted;
    logic            sub_ok;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] div_res;

    assign is_div    = (ALU_ctrl2 >= 5'd23) && (ALU_ctrl2 <= 5'd30);
    assign is_w      = (ALU_ctrl2 >= 5'd27);
    assign is_signed = (op == OP_DIV) || (op == OP_REM) || (op == OP_DIVW) || (op == OP_REMW);
    assign is_rem    = (op == OP_REM) || (op == OP_REMU) || (op == OP_REMW) || (op == OP_REMUW);
    assign alu_done  = is_div ? (state == S_DONE) : 1'b1;

    // Operand preparation: W ops narrow to 32 bits, signed ops take magnitudes.
    always_comb begin
        op_a = src_a;
        op_b = src_b;
        if (is_w) begin
            op_a = is_signed ? sext_w(src_a[HALF-1:0]) : {{HALF{1'b0}}, src_a[HALF-1:0]};
            op_b = is_signed ? sext_w(src_b[HALF-1:0]) : {{HALF{1'b0}}, src_b[HALF-1:0]};
        end
        sign_a = is_signed & op_a[XLEN-1];
        sign_b = is_signed & op_b[XLEN-1];
        mag_a  = sign_a ? -op_a : op_a;
        mag_b  = sign_b ? -op_b : op_b;
    end

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        shifted = {div_r, div_q[XLEN-1]};
        sub_ok  = (shifted >= {1'b0, div_d});
    end

    // Sign correction and special cases applied to the held quotient/remainder.
    always_comb begin
        q_fix = div_zero ? '1 : (neg_q ? -div_q : div_q);
        r_fix = neg_r ? -div_r : div_r;
        div_res = is_rem ? r_fix : q_fix;
        if (is_w) begin
            div_res = sext_w(div_res[HALF-1:0]);
        end
    end

    // Divider state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Divider next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (valid4 && is_div) state_next = S_BUSY;
            S_BUSY:  if (div_cnt == CNT_W'(1)) state_next = S_DONE;
            S_DONE:  if (fire) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Divider datapath: latch operands on entry, iterate one bit per cycle while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            div_r    <= '0;
            div_d    <= '0;
            div_cnt  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (state == S_IDLE) begin
            if (valid4 && is_div) begin
                div_q    <= is_w ? {mag_a[HALF-1:0], {HALF{1'b0}}} : mag_a;
                div_r    <= '0;
                div_d    <= mag_b;
                div_cnt  <= is_w ? CNT_W'(DIV_CYC / 2) : CNT_W'(DIV_CYC);
                neg_q    <= sign_a ^ sign_b;
                neg_r    <= sign_a;
                div_zero <= (op_b == '0);
            end
        end else if (state == S_BUSY) begin
            div_r   <= sub_ok ? XLEN'(shifted - {1'b0, div_d}) : shifted[XLEN-1:0];
            div_q   <= {div_q[XLEN-2:0], sub_ok};
            div_cnt <= div_cnt - CNT_W'(1);
        end
    end

    assign result = is_div ? div_res : alu_res;
`else
    assign alu_done = 1'b1;
    assign result   = alu_res;
`endif

    // EX/MEM pipeline register: capture on fire, bubble when MEM is ready, hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid5    <= 1'b0;
            PC5       <= '0;
            Ins4      <= '0;
            MEM_W_en3 <= 1'b0;
            WB_sel3   <= 1'b0;
            reg_w_en4 <= 1'b0;
            rdest2    <= '0;
            alu_out   <= '0;
            st_data   <= '0;
        end else if (fire) begin
            valid5    <= 1'b1;
            PC5       <= PC4;
            Ins4      <= Ins3;
            MEM_W_en3 <= MEM_W_en2;
            WB_sel3   <= WB_sel2;
            reg_w_en4 <= reg_w_en2;
            rdest2    <= rdest1;
            alu_out   <= result;
            st_data   <= rt_data1;
        end else if (ready5) begin
            valid5    <= 1'b0;
            MEM_W_en3 <= 1'b0;
            reg_w_en4 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_22041071_ex.sv
// Directed testbench for ysyx_22041071_ex. Expectations for MUL/DIV codes
// follow the YSYX_22041071_MULDIV_EN setting of the build.
module tb_ysyx_22041071_ex;

    logic        clk;
    logic        reset;
    logic        valid4;
    logic        ready5;
    logic        ready4;
    logic [63:0] PC4;
    logic [31:0] Ins3;
    logic        Brch2;
    logic        MEM_W_en2;
    logic        WB_sel2;
    logic [4:0]  ALU_ctrl2;
    logic        reg_w_en2;
    logic [63:0] rt_data1;
    logic [4:0]  rdest1;
    logic [63:0] src_a;
    logic [63:0] src_b;
    logic [11:0] BImm2;
    logic [63:0] result;
    logic [4:0]  rdest1_;
    logic        reg_w_en3_;
    logic        Brch_taken;
    logic [63:0] BPC;
    logic        valid5;
    logic [63:0] PC5;
    logic [31:0] Ins4;
    logic        MEM_W_en3;
    logic        WB_sel3;
    logic        reg_w_en4;
    logic [4:0]  rdest2;
    logic [63:0] alu_out;
    logic [63:0] st_data;

    int checks = 0;
    int errors = 0;

    ysyx_22041071_ex dut (
        .clk(clk), .reset(reset), .valid4(valid4), .ready5(ready5), .ready4(ready4),
        .PC4(PC4), .Ins3(Ins3), .Brch2(Brch2), .MEM_W_en2(MEM_W_en2), .WB_sel2(WB_sel2),
        .ALU_ctrl2(ALU_ctrl2), .reg_w_en2(reg_w_en2), .rt_data1(rt_data1), .rdest1(rdest1),
        .src_a(src_a), .src_b(src_b), .BImm2(BImm2), .result(result), .rdest1_(rdest1_),
        .reg_w_en3_(reg_w_en3_), .Brch_taken(Brch_taken), .BPC(BPC), .valid5(valid5),
        .PC5(PC5), .Ins4(Ins4), .MEM_W_en3(MEM_W_en3), .WB_sel3(WB_sel3),
        .reg_w_en4(reg_w_en4), .rdest2(rdest2), .alu_out(alu_out), .st_data(st_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        valid4 = 0; ready5 = 1; PC4 = '0; Ins3 = '0; Brch2 = 0; MEM_W_en2 = 0;
        WB_sel2 = 0; ALU_ctrl2 = '0; reg_w_en2 = 0; rt_data1 = '0; rdest1 = '0;
        src_a = '0; src_b = '0; BImm2 = '0;
    endtask

    task automatic set_op(input logic [4:0] ctrl, input logic [63:0] a, input logic [63:0] b);
        valid4 = 1; ready5 = 1; PC4 = 64'h8000_0100; Ins3 = 32'h0000_0033; Brch2 = 0;
        MEM_W_en2 = 0; WB_sel2 = 1; ALU_ctrl2 = ctrl; reg_w_en2 = 1; rt_data1 = 64'h55;
        rdest1 = 5'd10; src_a = a; src_b = b; BImm2 = '0;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1;
        tick();
        tick();
        checks++; if (valid5 !== 1'b0) begin errors++; $display("FAIL reset_valid5: got %b expected 0", valid5); end
        checks++; if (alu_out !== 64'h0) begin errors++; $display("FAIL reset_alu_out: got %h expected 0", alu_out); end
        checks++; if (PC5 !== 64'h0) begin errors++; $display("FAIL reset_pc5: got %h expected 0", PC5); end
        checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL reset_ready4: got %b expected 1", ready4); end
        reset = 0;
    endtask

    task automatic test_add();
        set_op(5'd0, 64'd5, -64'sd7);
        #1;
        checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL add_result: got %h expected fffffffffffffffe", result); end
        checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL add_ready4: got %b expected 1", ready4); end
        checks++; if (reg_w_en3_ !== 1'b1 || rdest1_ !== 5'd10) begin errors++; $display("FAIL add_fwd: got %b/%0d expected 1/10", reg_w_en3_, rdest1_); end
        tick();
        checks++; if (alu_out !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL add_alu_out: got %h expected fffffffffffffffe", alu_out); end
        checks++; if (valid5 !== 1'b1 || reg_w_en4 !== 1'b1 || WB_sel3 !== 1'b1) begin errors++; $display("FAIL add_ctrl: got v%b w%b s%b expected 1 1 1", valid5, reg_w_en4, WB_sel3); end
        checks++; if (PC5 !== 64'h8000_0100 || rdest2 !== 5'd10 || st_data !== 64'h55) begin errors++; $display("FAIL add_regs: got pc %h rd %0d st %h", PC5, rdest2, st_data); end
        set_idle();
        tick();
        checks++; if (valid5 !== 1'b0 || reg_w_en4 !== 1'b0) begin errors++; $display("FAIL add_drain: got v%b w%b expected 0 0", valid5, reg_w_en4); end
        checks++; if (alu_out !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL add_drain_hold: got %h expected fffffffffffffffe", alu_out); end
    endtask

    task automatic test_alu();
        logic [4:0]  ctrl [16];
        logic [63:0] va   [16];
        logic [63:0] vb   [16];
        logic [63:0] ve   [16];
        ctrl[0]  = 5'd1;  va[0]  = 64'd10;                vb[0]  = 64'd3;  ve[0]  = 64'd7;
        ctrl[1]  = 5'd2;  va[1]  = 64'd1;                 vb[1]  = 64'h41; ve[1]  = 64'd2;
        ctrl[2]  = 5'd3;  va[2]  = '1;                    vb[2]  = 64'd1;  ve[2]  = 64'd1;
        ctrl[3]  = 5'd4;  va[3]  = '1;                    vb[3]  = 64'd1;  ve[3]  = 64'd0;
        ctrl[4]  = 5'd5;  va[4]  = 64'hF0;                vb[4]  = 64'hFF; ve[4]  = 64'h0F;
        ctrl[5]  = 5'd6;  va[5]  = 64'h8000_0000_0000_0000; vb[5] = 64'd4; ve[5]  = 64'h0800_0000_0000_0000;
        ctrl[6]  = 5'd7;  va[6]  = 64'h8000_0000_0000_0000; vb[6] = 64'd4; ve[6]  = 64'hF800_0000_0000_0000;
        ctrl[7]  = 5'd8;  va[7]  = 64'hF0;                vb[7]  = 64'h0F; ve[7]  = 64'hFF;
        ctrl[8]  = 5'd9;  va[8]  = 64'hF0;                vb[8]  = 64'h3C; ve[8]  = 64'h30;
        ctrl[9]  = 5'd10; va[9]  = 64'h7FFF_FFFF;         vb[9]  = 64'd1;  ve[9]  = 64'hFFFF_FFFF_8000_0000;
        ctrl[10] = 5'd11; va[10] = 64'h1234_5678_0000_0000; vb[10] = 64'd1; ve[10] = 64'hFFFF_FFFF_FFFF_FFFF;
        ctrl[11] = 5'd12; va[11] = 64'd1;                 vb[11] = 64'h3F; ve[11] = 64'hFFFF_FFFF_8000_0000;
        ctrl[12] = 5'd13; va[12] = 64'hFFFF_FFFF_8000_0000; vb[12] = 64'd4; ve[12] = 64'h0000_0000_0800_0000;
        ctrl[13] = 5'd14; va[13] = 64'h0000_0000_8000_0000; vb[13] = 64'd4; ve[13] = 64'hFFFF_FFFF_F800_0000;
        ctrl[14] = 5'd31; va[14] = 64'd5;                 vb[14] = 64'd5;  ve[14] = 64'd0;
        ctrl[15] = 5'd15; va[15] = 64'd3;                 vb[15] = 64'd3;  ve[15] = 64'd0;
        for (int i = 0; i < 16; i++) begin
            set_op(ctrl[i], va[i], vb[i]);
            #1;
            checks++; if (result !== ve[i]) begin errors++; $display("FAIL alu_op%0d: got %h expected %h", ctrl[i], result, ve[i]); end
            tick();
        end
        set_idle();
        tick();
    endtask

    task automatic test_hold();
        set_op(5'd0, 64'd1, 64'd2);
        tick();
        set_op(5'd0, 64'd10, 64'd10);
        ready5 = 0;
        #1;
        checks++; if (ready4 !== 1'b0) begin errors++; $display("FAIL hold_ready4: got %b expected 0", ready4); end
        tick();
        checks++; if (alu_out !== 64'd3 || valid5 !== 1'b1) begin errors++; $display("FAIL hold_regs: got %h v%b expected 3 v1", alu_out, valid5); end
        ready5 = 1;
        tick();
        checks++; if (alu_out !== 64'd20) begin errors++; $display("FAIL hold_release: got %h expected 20", alu_out); end
        set_idle();
        tick();
    endtask

    task automatic test_bubble();
        set_op(5'd0, 64'd7, 64'd1);
        tick();
        set_idle();
        valid4 = 1;
        tick();
        checks++; if (valid5 !== 1'b1 || alu_out !== 64'd0 || Ins4 !== 32'd0) begin errors++; $display("FAIL bubble_regs: got v%b %h ins %h expected v1 0 0", valid5, alu_out, Ins4); end
        checks++; if (reg_w_en4 !== 1'b0 || MEM_W_en3 !== 1'b0) begin errors++; $display("FAIL bubble_writes: got w%b m%b expected 0 0", reg_w_en4, MEM_W_en3); end
        set_idle();
        tick();
    endtask

    task automatic test_branch();
        set_op(5'd17, '1, 64'd1);
        Brch2 = 1; reg_w_en2 = 0; PC4 = 64'h8000_0010; BImm2 = 12'hFF8;
        #1;
        checks++; if (Brch_taken !== 1'b1) begin errors++; $display("FAIL blt_taken: got %b expected 1", Brch_taken); end
        checks++; if (BPC !== 64'h8000_0000) begin errors++; $display("FAIL blt_bpc: got %h expected 80000000", BPC); end
        checks++; if (result !== 64'd0) begin errors++; $display("FAIL blt_result: got %h expected 0", result); end
        tick();
        set_idle();
        #1;
        checks++; if (Brch_taken !== 1'b0) begin errors++; $display("FAIL blt_pulse: got %b expected 0", Brch_taken); end
        set_op(5'd18, '1, 64'd1);
        Brch2 = 1;
        #1;
        checks++; if (Brch_taken !== 1'b0) begin errors++; $display("FAIL bge_taken: got %b expected 0", Brch_taken); end
        ALU_ctrl2 = 5'd19;
        #1;
        checks++; if (Brch_taken !== 1'b0) begin errors++; $display("FAIL bltu_taken: got %b expected 0", Brch_taken); end
        ALU_ctrl2 = 5'd16; BImm2 = 12'h004;
        #1;
        checks++; if (Brch_taken !== 1'b1 || BPC !== 64'h8000_0108) begin errors++; $display("FAIL bne_taken: got %b %h expected 1 80000108", Brch_taken, BPC); end
        valid4 = 0;
        #1;
        checks++; if (Brch_taken !== 1'b0) begin errors++; $display("FAIL bne_novalid: got %b expected 0", Brch_taken); end
        set_idle();
        tick();
    endtask

`ifdef YSYX_22041071_MULDIV_EN
    task automatic run_div(input logic [4:0] ctrl, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] expv, input int exp_cyc);
        int cnt;
        set_op(ctrl, a, b);
        #1;
        cnt = 0;
        while (ready4 !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        checks++; if (cnt != exp_cyc) begin errors++; $display("FAIL div%0d_latency: got %0d expected %0d", ctrl, cnt, exp_cyc); end
        checks++; if (result !== expv) begin errors++; $display("FAIL div%0d_result: got %h expected %h", ctrl, result, expv); end
        tick();
        checks++; if (alu_out !== expv || valid5 !== 1'b1) begin errors++; $display("FAIL div%0d_retire: got %h v%b expected %h v1", ctrl, alu_out, valid5, expv); end
    endtask

    task automatic test_muldiv();
        set_op(5'd21, 64'd3, -64'sd2);
        #1;
        checks++; if (result !== -64'sd6 || ready4 !== 1'b1) begin errors++; $display("FAIL mul: got %h r%b expected fffffffffffffffa r1", result, ready4); end
        set_op(5'd22, 64'h8000, 64'h1_0000);
        #1;
        checks++; if (result !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL mulw: got %h expected ffffffff80000000", result); end
        tick();
        run_div(5'd23, -64'sd20, 64'd3, -64'sd6, 65);
        run_div(5'd25, -64'sd20, 64'd3, -64'sd2, 65);
        run_div(5'd24, 64'd9, 64'd0, '1, 65);
        run_div(5'd26, 64'd9, 64'd0, 64'd9, 65);
        run_div(5'd23, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 65);
        run_div(5'd25, 64'h8000_0000_0000_0000, '1, 64'd0, 65);
        run_div(5'd23, -64'sd20, 64'd0, '1, 65);
        run_div(5'd25, -64'sd20, 64'd0, -64'sd20, 65);
        run_div(5'd27, 64'h0000_0000_FFFF_FFEC, 64'd3, -64'sd6, 33);
        run_div(5'd30, 64'd7, 64'd0, 64'd7, 33);
        set_idle();
        tick();
    endtask

    task automatic test_div_stall();
        logic [63:0] held_out;
        logic        held_v;
        int cnt;
        set_op(5'd27, 64'd100, 64'd7);
        #1;
        cnt = 0;
        while (ready4 !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        checks++; if (cnt != 33) begin errors++; $display("FAIL stall_latency: got %0d expected 33", cnt); end
        ready5 = 0;
        held_out = alu_out;
        held_v = valid5;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (ready4 !== 1'b0 || result !== 64'd14) begin errors++; $display("FAIL stall_done%0d: got r%b %h expected r0 14", i, ready4, result); end
            checks++; if (alu_out !== held_out || valid5 !== held_v) begin errors++; $display("FAIL stall_hold%0d: got %h v%b expected %h v%b", i, alu_out, valid5, held_out, held_v); end
        end
        ready5 = 1;
        #1;
        checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL stall_release: got %b expected 1", ready4); end
        tick();
        checks++; if (alu_out !== 64'd14 || valid5 !== 1'b1) begin errors++; $display("FAIL stall_retire: got %h v%b expected 14 v1", alu_out, valid5); end
        set_idle();
        tick();
        checks++; if (valid5 !== 1'b0) begin errors++; $display("FAIL stall_single: got %b expected 0", valid5); end
    endtask
`else
    task automatic test_no_muldiv();
        set_op(5'd21, 64'd3, 64'd4);
        #1;
        checks++; if (result !== 64'd0 || ready4 !== 1'b1) begin errors++; $display("FAIL nomul: got %h r%b expected 0 r1", result, ready4); end
        set_op(5'd23, 64'd20, 64'd3);
        #1;
        checks++; if (result !== 64'd0 || ready4 !== 1'b1) begin errors++; $display("FAIL nodiv: got %h r%b expected 0 r1", result, ready4); end
        tick();
        checks++; if (alu_out !== 64'd0 || valid5 !== 1'b1) begin errors++; $display("FAIL nodiv_retire: got %h v%b expected 0 v1", alu_out, valid5); end
        set_idle();
        tick();
    endtask
`endif

    task automatic test_reset_mid_div();
        set_op(5'd0, 64'd40, 64'd2);
        tick();
        set_op(5'd23, -64'sd20, 64'd3);
        repeat (20) tick();
`ifdef YSYX_22041071_MULDIV_EN
        checks++; if (ready4 !== 1'b0) begin errors++; $display("FAIL rstdiv_busy: got %b expected 0", ready4); end
`endif
        reset = 1;
        set_op(5'd0, 64'd2, 64'd3);
        tick();
        reset = 0;
        checks++; if (valid5 !== 1'b0 || alu_out !== 64'd0) begin errors++; $display("FAIL rstdiv_regs: got v%b %h expected v0 0", valid5, alu_out); end
        checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL rstdiv_ready4: got %b expected 1", ready4); end
        tick();
        checks++; if (alu_out !== 64'd5 || valid5 !== 1'b1) begin errors++; $display("FAIL rstdiv_add: got %h v%b expected 5 v1", alu_out, valid5); end
        set_idle();
        tick();
    endtask

    initial begin
        reset = 1;
        set_idle();
        test_reset();
        test_add();
        test_alu();
        test_hold();
        test_bubble();
        test_branch();
`ifdef YSYX_22041071_MULDIV_EN
        test_muldiv();
        test_div_stall();
`else
        test_no_muldiv();
`endif
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
